// File: rtl/cache_refill_ctrl_if.sv
// Signal bundle for cache_refill_ctrl: miss handshake, PULPino req/gnt/rvalid data bus and cache-memory write port.
// master = refill controller side, slave = lookup FSM / bus / cache memory side.
interface cache_refill_ctrl_if #(
  parameter int WAY_COUNT      = 2,
  parameter int SET_COUNT      = 64,
  parameter int WAY_WORD_COUNT = 4
);
  localparam int WAY_W  = $clog2(WAY_COUNT);
  localparam int SET_W  = $clog2(SET_COUNT);
  localparam int WI     = $clog2(WAY_WORD_COUNT);
  localparam int TAG_W  = 32 - WI - 2 - SET_W;
  localparam int LINE_W = 32 * WAY_WORD_COUNT;

  logic                      miss_valid_i;
  logic [31:0]               miss_addr_i;
  logic                      miss_ready_o;
  logic                      refill_done_o;
  logic [WAY_W-1:0]          refill_way_o;

  logic                      mem_req_o;
  logic [31:0]               mem_addr_o;
  logic                      mem_gnt_i;
  logic                      mem_rvalid_i;
  logic [31:0]               mem_rdata_i;

  logic [SET_W-1:0]          cm_set_o;
  logic [WAY_W-1:0]          cm_way_o;
  logic                      cm_enable_o;
  logic                      cm_write_enable_o;
  logic                      cm_line_valid_o;
  logic [TAG_W-1:0]          cm_line_tag_o;
  logic [LINE_W-1:0]         cm_line_o;
  logic [WAY_WORD_COUNT-1:0] cm_line_ww_enable_o;
  logic [WAY_COUNT-1:0]      cm_line_valid_i;

  modport master (
    input  miss_valid_i, miss_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, cm_line_valid_i,
    output miss_ready_o, refill_done_o, refill_way_o, mem_req_o, mem_addr_o,
           cm_set_o, cm_way_o, cm_enable_o, cm_write_enable_o, cm_line_valid_o,
           cm_line_tag_o, cm_line_o, cm_line_ww_enable_o
  );

  modport slave (
    output miss_valid_i, miss_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, cm_line_valid_i,
    input  miss_ready_o, refill_done_o, refill_way_o, mem_req_o, mem_addr_o,
           cm_set_o, cm_way_o, cm_enable_o, cm_write_enable_o, cm_line_valid_o,
           cm_line_tag_o, cm_line_o, cm_line_ww_enable_o
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache line refill: picks a victim way, fetches the line word by word, writes tag/valid/line in one cycle.
// Optional macro CACHE_REFILL_CRITICAL_WORD_FIRST_EN starts the fetch at the missed word and wraps.
module cache_refill_ctrl #(
  parameter int WAY_COUNT      = 2,
  parameter int SET_COUNT      = 64,
  parameter int WAY_WORD_COUNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  cache_refill_ctrl_if.master bus,
  output logic [2:0]          dbg_state
);
  localparam int WAY_W  = $clog2(WAY_COUNT);
  localparam int SET_W  = $clog2(SET_COUNT);
  localparam int WI     = $clog2(WAY_WORD_COUNT);
  localparam int LA_W   = 32 - WI - 2;
  localparam int TAG_W  = LA_W - SET_W;
  localparam int LINE_W = 32 * WAY_WORD_COUNT;

  // Handshakes: a miss is taken on miss_valid_i && miss_ready_o; a bus word is requested
  // on mem_req_o && mem_gnt_i and completes on the next mem_rvalid_i (one transfer in flight).
  typedef enum logic [2:0] {S_IDLE, S_VICTIM, S_REQ, S_WAIT, S_WRITE} state_t;

  state_t            state, state_next;
  logic [LA_W-1:0]   line_addr;
  logic [WI-1:0]     start_idx, word_idx, word_cnt;
  logic [WAY_W-1:0]  rr_ptr, victim, free_way;
  logic              free_found;
  logic [LINE_W-1:0] line_buf;
  logic              unused_addr_bits;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  logic [WI-1:0] miss_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_word <= '0;
    end else if (state == S_IDLE && bus.miss_valid_i) begin
      miss_word <= bus.miss_addr_i[WI+1:2];
    end
  end

  assign start_idx        = miss_word;
  assign unused_addr_bits = ^bus.miss_addr_i[1:0];
`else
  assign start_idx        = '0;
  assign unused_addr_bits = ^bus.miss_addr_i[WI+1:0];
`endif

  // Lowest-index invalid way; the round-robin pointer only matters when the set is full.
  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int i = WAY_COUNT - 1; i >= 0; i--) begin
      if (!bus.cm_line_valid_i[i]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      line_addr <= '0;
      rr_ptr    <= '0;
      victim    <= '0;
      word_idx  <= '0;
      word_cnt  <= '0;
      line_buf  <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (bus.miss_valid_i) line_addr <= bus.miss_addr_i[31:WI+2];
        end
        S_VICTIM: begin
          victim   <= free_found ? free_way : rr_ptr;
          if (!free_found) rr_ptr <= rr_ptr + 1'b1;
          word_idx <= start_idx;
          word_cnt <= '0;
        end
        S_WAIT: begin
          if (bus.mem_rvalid_i) begin
            for (int k = 0; k < WAY_WORD_COUNT; k++) begin
              if (word_idx == WI'(k)) line_buf[k*32 +: 32] <= bus.mem_rdata_i;
            end
            word_idx <= word_idx + 1'b1;
            word_cnt <= word_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next              = state;
    bus.miss_ready_o        = 1'b0;
    bus.mem_req_o           = 1'b0;
    bus.cm_enable_o         = 1'b0;
    bus.cm_write_enable_o   = 1'b0;
    bus.cm_line_valid_o     = 1'b0;
    bus.cm_line_ww_enable_o = '0;
    bus.refill_done_o       = 1'b0;
    bus.refill_way_o        = '0;
    case (state)
      S_IDLE: begin
        bus.miss_ready_o = 1'b1;
        if (bus.miss_valid_i) state_next = S_VICTIM;
      end
      S_VICTIM: begin
        bus.cm_enable_o = 1'b1;
        state_next      = S_REQ;
      end
      S_REQ: begin
        bus.mem_req_o = 1'b1;
        if (bus.mem_gnt_i) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_rvalid_i) begin
          state_next = (word_cnt == WI'(WAY_WORD_COUNT - 1)) ? S_WRITE : S_REQ;
        end
      end
      S_WRITE: begin
        bus.cm_enable_o         = 1'b1;
        bus.cm_write_enable_o   = 1'b1;
        bus.cm_line_valid_o     = 1'b1;
        bus.cm_line_ww_enable_o = '1;
        bus.refill_done_o       = 1'b1;
        bus.refill_way_o        = victim;
        state_next              = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.mem_addr_o    = {line_addr, word_idx, 2'b00};
  assign bus.cm_set_o      = line_addr[SET_W-1:0];
  assign bus.cm_line_tag_o = line_addr[LA_W-1:SET_W];
  assign bus.cm_way_o      = victim;
  assign bus.cm_line_o     = line_buf;
  assign dbg_state         = state;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: reference model predicts victim, fetch order and line
// per accepted miss; a bus responder and a done monitor pop and compare independently.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;
  localparam int WAY_COUNT      = 2;
  localparam int SET_COUNT      = 64;
  localparam int WAY_WORD_COUNT = 4;
  localparam int WAY_W  = $clog2(WAY_COUNT);
  localparam int SET_W  = $clog2(SET_COUNT);
  localparam int WI     = $clog2(WAY_WORD_COUNT);
  localparam int TAG_W  = 32 - WI - 2 - SET_W;
  localparam int LINE_W = 32 * WAY_WORD_COUNT;
  localparam int EXP_W  = WAY_W + SET_W + TAG_W + LINE_W;

  typedef struct packed {
    logic [WAY_W-1:0]  way;
    logic [SET_W-1:0]  set;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  cache_refill_ctrl_if #(.WAY_COUNT(WAY_COUNT), .SET_COUNT(SET_COUNT), .WAY_WORD_COUNT(WAY_WORD_COUNT)) bus();

  cache_refill_ctrl #(.WAY_COUNT(WAY_COUNT), .SET_COUNT(SET_COUNT), .WAY_WORD_COUNT(WAY_WORD_COUNT)) dut (
    .clk(clk), .reset(reset), .bus(bus.master), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  int               lat_q[$];
  logic [31:0]      addr_q[$];
  logic [31:0]      seen_addrs[$];
  int               rr_model = 0;
  logic [31:0]      salt = 32'h0;
  bit               zero_wait = 1'b1;
  bit               stray_en = 1'b0;
  int               fixed_wait = -1;
  int               words_done = 0;
  bit               pending = 1'b0;
  logic [31:0]      first_rdata = 32'h0;
  int               done_cnt = 0;
  int               en_cycles = 0;
  logic [WAY_W-1:0]  last_way;
  logic [SET_W-1:0]  last_set;
  logic [TAG_W-1:0]  last_tag;
  logic [LINE_W-1:0] last_line;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Reference model: victim policy, fetch order and assembled line from the address rules.
  task automatic predict(input logic [31:0] addr, input logic [WAY_COUNT-1:0] vbits, input bit chk_lat);
    int way = -1;
    int start;
    logic [31:0] base;
    exp_t e;
    for (int i = 0; i < WAY_COUNT; i++) if (!vbits[i] && way < 0) way = i;
    if (way < 0) begin
      way = rr_model;
      rr_model = (rr_model + 1) % WAY_COUNT;
    end
    base = addr & ~32'(WAY_WORD_COUNT * 4 - 1);
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    start = int'((addr >> 2) % WAY_WORD_COUNT);
`else
    start = 0;
`endif
    for (int k = 0; k < WAY_WORD_COUNT; k++)
      addr_q.push_back(base + 32'(((start + k) % WAY_WORD_COUNT) * 4));
    e.line = '0;
    for (int j = 0; j < WAY_WORD_COUNT; j++) e.line[j*32 +: 32] = mem_data(base + 32'(j * 4));
    e.way = WAY_W'(way);
    e.set = SET_W'((addr >> (WI + 2)) % SET_COUNT);
    e.tag = TAG_W'(addr >> (WI + 2 + SET_W));
    exp_q.push_back(e);
    lat_q.push_back(chk_lat ? cyc : -1);
  endtask

  // ---------------- bus responder / address checker ----------------
  bit          req_seen = 1'b0;
  bit          gnt_drv = 1'b0;
  bit          rv_real = 1'b0;
  int          delay = 0;
  int          req_wait = 0;
  logic [31:0] addr_seen = 32'h0;
  logic [31:0] gnt_addr = 32'h0;

  always @(negedge clk) begin
    if (reset) begin
      pending = 1'b0; req_seen = 1'b0; gnt_drv = 1'b0; rv_real = 1'b0; req_wait = 0;
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    end else begin
      if (rv_real) begin
        pending = 1'b0;
        words_done++;
        if (words_done == 1) first_rdata = bus.mem_rdata_i;
      end
      if (req_seen && gnt_drv) begin
        pending  = 1'b1;
        delay    = zero_wait ? 0 : $urandom_range(0, 2);
        gnt_addr = addr_seen;
        req_wait = 0;
        seen_addrs.push_back(addr_seen);
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_addr_unexpected: got %h expected none", addr_seen);
        end else check("mem_addr", addr_seen, addr_q.pop_front());
      end else if (req_seen) begin
        check("req_held", bus.mem_req_o, 1'b1);
        check("addr_held", bus.mem_addr_o, addr_seen);
        req_wait++;
      end
      gnt_drv = 1'b0; rv_real = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = $urandom;
      if (pending) begin
        if (delay == 0) begin
          bus.mem_rvalid_i = 1'b1; rv_real = 1'b1;
          bus.mem_rdata_i  = mem_data(gnt_addr);
        end else delay--;
      end else if (stray_en && $urandom_range(0, 3) == 0) bus.mem_rvalid_i = 1'b1;
      if (bus.mem_req_o && !pending)
        gnt_drv = zero_wait || (fixed_wait >= 0 ? (req_wait >= fixed_wait) : ($urandom_range(0, 2) == 0));
      else if (!bus.mem_req_o && stray_en)
        gnt_drv = ($urandom_range(0, 3) == 0);
      bus.mem_gnt_i = gnt_drv;
      req_seen  = bus.mem_req_o;
      addr_seen = bus.mem_addr_o;
    end
  end

  // ---------------- done monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cm_enable_o) en_cycles++;
      check("we_vs_done", bus.cm_write_enable_o, bus.refill_done_o);
      if (bus.refill_done_o) begin
        exp_t e;
        int   lat;
        done_cnt++;
        last_way = bus.refill_way_o; last_set = bus.cm_set_o;
        last_tag = bus.cm_line_tag_o; last_line = bus.cm_line_o;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done expected none");
        end else begin
          e   = exp_q.pop_front();
          lat = lat_q.pop_front();
          check("refill_way", bus.refill_way_o, e.way);
          check("cm_way", bus.cm_way_o, e.way);
          check("cm_set", bus.cm_set_o, e.set);
          check("cm_tag", bus.cm_line_tag_o, e.tag);
          check("cm_line", bus.cm_line_o, e.line);
          check("ww_enable", bus.cm_line_ww_enable_o, {WAY_WORD_COUNT{1'b1}});
          check("line_valid", bus.cm_line_valid_o, 1'b1);
          check("enable_cycles", en_cycles, 2);
          // done lands in the 11th cycle counting the accept cycle as the first
          if (lat >= 0) check("latency", cyc - lat, 2 * WAY_WORD_COUNT + 2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept_miss(input logic [31:0] addr, input logic [WAY_COUNT-1:0] vbits, input bit chk_lat,
                             output bit ok);
    int t = 0;
    @(negedge clk); #1;
    while (!bus.miss_ready_o && t < 100) begin @(negedge clk); #1; t++; end
    checks++;
    ok = bus.miss_ready_o;
    if (!ok) begin errors++; $display("FAIL ready_timeout: got 0 expected 1"); return; end
    salt = $urandom;
    words_done = 0; en_cycles = 0;
    bus.cm_line_valid_i = vbits;
    bus.miss_addr_i     = addr;
    bus.miss_valid_i    = 1'b1;
    predict(addr, vbits, chk_lat);
    @(negedge clk); #1;
    bus.miss_valid_i = 1'b0;
    bus.miss_addr_i  = $urandom;
  endtask

  task automatic run_miss(input logic [31:0] addr, input logic [WAY_COUNT-1:0] vbits, input bit chk_lat,
                          input bit pulses);
    int t = 0;
    int d0;
    bit ok;
    d0 = done_cnt;
    accept_miss(addr, vbits, chk_lat, ok);
    if (!ok) return;
    while (done_cnt == d0 && t < 300) begin
      if (pulses && !bus.miss_ready_o && $urandom_range(0, 2) == 0) begin
        bus.miss_valid_i = 1'b1;
        bus.miss_addr_i  = $urandom;
      end else bus.miss_valid_i = 1'b0;
      @(negedge clk); #1; t++;
    end
    bus.miss_valid_i = 1'b0;
    checks++;
    if (done_cnt == d0) begin errors++; $display("FAIL done_timeout: got no done expected done"); end
  endtask

  task automatic reset_mid_refill(input logic [31:0] addr);
    int t = 0;
    bit ok;
    accept_miss(addr, '0, 1'b0, ok);
    if (!ok) return;
    while (!(words_done == 2 && pending) && t < 200) begin @(negedge clk); #1; t++; end
    check("reach_third_word", words_done, 2);
    reset = 1'b1;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    addr_q.delete();
    rr_model = 0;
    @(negedge clk);
    check("rst_no_write", bus.cm_write_enable_o, 1'b0);
    check("rst_no_done", bus.refill_done_o, 1'b0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.miss_ready_o, 1'b1);
    check("req_after_reset", bus.mem_req_o, 1'b0);
    check("en_after_reset", bus.cm_enable_o, 1'b0);
    check("done_after_reset", bus.refill_done_o, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] exp_order[WAY_WORD_COUNT];
  logic [31:0] a;

  initial begin
    reset = 1'b1;
    bus.miss_valid_i = 1'b0; bus.miss_addr_i = '0; bus.cm_line_valid_i = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.miss_ready_o, 1'b1);
    check("rst_done", bus.refill_done_o, 1'b0);
    check("rst_req", bus.mem_req_o, 1'b0);
    check("rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("rst_cm_en", bus.cm_enable_o, 1'b0);
    check("rst_cm_we", bus.cm_write_enable_o, 1'b0);
    check("rst_line", bus.cm_line_o, '0);
    check("rst_set", bus.cm_set_o, '0);
    #1 reset = 1'b0;

    // Directed miss 0x1234 on a zero-wait bus.
    seen_addrs.delete();
    run_miss(32'h0000_1234, 2'b00, 1'b1, 1'b0);
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    exp_order = '{32'h1234, 32'h1238, 32'h123C, 32'h1230};
    check("cwf_word1_first_data", last_line[63:32], first_rdata);
`else
    exp_order = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
    check("word0_first_data", last_line[31:0], first_rdata);
`endif
    check("dir_addr_count", seen_addrs.size(), WAY_WORD_COUNT);
    for (int i = 0; i < WAY_WORD_COUNT && i < seen_addrs.size(); i++) check("dir_addr_order", seen_addrs[i], exp_order[i]);
    check("dir_set", last_set, 6'h23);
    check("dir_tag", last_tag, 22'h4);
    check("dir_way", last_way, 1'b0);

    // Victim selection and round-robin wrap.
    run_miss(32'h0000_2040, 2'b01, 1'b1, 1'b0);
    check("dir_victim_free1", last_way, 1'b1);
    run_miss(32'h0000_3080, 2'b11, 1'b1, 1'b0);
    check("dir_victim_rr0", last_way, 1'b0);
    run_miss(32'h0000_40C0, 2'b11, 1'b1, 1'b0);
    check("dir_victim_rr1", last_way, 1'b1);
    run_miss(32'h0000_5100, 2'b11, 1'b1, 1'b0);
    check("dir_victim_rr2", last_way, 1'b0);

    // Grant withheld three cycles with stray rvalid/gnt around it.
    zero_wait = 1'b0; stray_en = 1'b1; fixed_wait = 3;
    run_miss(32'hDEAD_BEEC, 2'b10, 1'b0, 1'b0);

    // Reset while the third word is in flight, then a fresh miss.
    fixed_wait = -1;
    reset_mid_refill(32'h0000_6608);
    run_miss(32'h0000_7714, 2'b11, 1'b0, 1'b0);
    check("rr_restart_after_reset", last_way, 1'b0);

    // Miss pulses during a refill are ignored.
    run_miss(32'h0000_8828, 2'b11, 1'b0, 1'b1);
    run_miss(32'h0000_993C, 2'b00, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      run_miss(a, ($urandom_range(0, 1) == 1) ? 2'b11 : WAY_COUNT'($urandom_range(0, 3)),
               1'b0, $urandom_range(0, 1) == 1);
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
